// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU datapath and its pipeline sequencing logic.
package cpu_types_pkg;

  localparam int REG_W_DEF = 5;

  typedef logic [REG_W_DEF-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    IWAIT  = 2'd2,
    HALTED = 2'd3
  } pctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_load_use.sv
// Flags a load in EX whose destination feeds either source of the instruction in ID.
module load_use_detect #(
  parameter int REG_W = cpu_types_pkg::REG_W_DEF
) (
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hazard = ex_memread && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: advance decision, hazard/flush overrides, halt latch, stall counter.
//   state  | meaning
//   RUN    | no hit latched, waiting for the cycle's fetch (and data access if any)
//   DWAIT  | ihit already seen, waiting for dhit
//   IWAIT  | dhit already seen, waiting for ihit
//   HALTED | halt retired in WB; pipe frozen until reset
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int REG_W = REG_W_DEF
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             branch_taken,
  input  logic             jump_id,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             halt_wb,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_flush,
  output logic             exmem_wen,
  output logic             exmem_flush,
  output logic             memwb_wen,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t state;
  logic         dreq;
  logic         adv;
  logic         hazard;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .hazard     (hazard)
  );

  assign dreq = mem_dren || mem_dwen;

  always_comb begin
    adv = 1'b0;
    unique case (state)
      RUN:     adv = ihit && (!dreq || dhit);
      DWAIT:   adv = dhit;
      IWAIT:   adv = ihit;
      HALTED:  adv = 1'b0;
      default: adv = 1'b0;
    endcase
  end

  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b0;
    idex_flush  = 1'b0;
    exmem_wen   = 1'b0;
    exmem_flush = 1'b0;
    memwb_wen   = 1'b0;
    if (nRST && adv) begin
      pc_wen    = 1'b1;
      ifid_wen  = 1'b1;
      idex_wen  = 1'b1;
      exmem_wen = 1'b1;
      memwb_wen = 1'b1;
      // A taken branch kills the younger instructions, so a load-use stall on them is moot.
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (hazard) begin
        pc_wen     = 1'b0;
        ifid_wen   = 1'b0;
        idex_flush = 1'b1;
      end else if (jump_id) begin
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      if (state != HALTED && !adv && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (adv) begin
        state <= halt_wb ? HALTED : RUN;
      end else if (state == RUN) begin
        if (ihit && dreq && !dhit)
          state <= DWAIT;
        else if (dhit && !ihit)
          state <= IWAIT;
      end
    end
  end

  assign halt = (state == HALTED) && nRST;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic vs a flag-based model.
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;
  localparam int REG_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [7:0] O_NONE   = 8'b0000_0000;
  localparam logic [7:0] O_ADV    = 8'b1101_0101;
  localparam logic [7:0] O_BUBBLE = 8'b0001_1101;
  localparam logic [7:0] O_BRANCH = 8'b1111_1111;
  localparam logic [7:0] O_JUMP   = 8'b1111_0101;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, mem_dren, mem_dwen, branch_taken, jump_id, ex_memread, halt_wb;
  logic [REG_W-1:0] ex_rt, id_rs, id_rt;
  logic pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush, memwb_wen;
  logic halt;
  logic [CNT_W-1:0] stall_cnt;
  logic [7:0] outs;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  bit m_iseen, m_dseen, m_halted;
  int m_cnt;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
    .branch_taken(branch_taken), .jump_id(jump_id), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .halt_wb(halt_wb), .pc_wen(pc_wen), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .idex_wen(idex_wen), .idex_flush(idex_flush), .exmem_wen(exmem_wen),
    .exmem_flush(exmem_flush), .memwb_wen(memwb_wen), .halt(halt), .stall_cnt(stall_cnt)
  );

  assign outs = {pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush, exmem_wen, exmem_flush, memwb_wen};

  // Model: "which hits are still outstanding" rather than a state machine.
  function automatic bit model_adv();
    if (m_halted) return 1'b0;
    if (m_iseen)  return dhit;
    if (m_dseen)  return ihit;
    return ihit && (!(mem_dren || mem_dwen) || dhit);
  endfunction

  function automatic logic [7:0] model_outs();
    bit hz;
    if (!nRST || !model_adv()) return O_NONE;
    hz = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
    if (branch_taken) return O_BRANCH;
    if (hz)           return O_BUBBLE;
    if (jump_id)      return O_JUMP;
    return O_ADV;
  endfunction

  always @(posedge CLK) begin
    bit a;
    if (!nRST) begin
      m_iseen = 0; m_dseen = 0; m_halted = 0; m_cnt = 0;
    end else begin
      a = model_adv();
      if (!m_halted && !a && m_cnt < CMAX) m_cnt++;
      if (a) begin
        m_iseen = 0; m_dseen = 0;
        if (halt_wb) m_halted = 1;
      end else if (!m_halted && !m_iseen && !m_dseen) begin
        m_iseen = ihit && (mem_dren || mem_dwen) && !dhit;
        m_dseen = dhit && !ihit;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_outs", int'(outs), int'(model_outs()));
      check("model_halt", int'(halt), int'(m_halted && nRST));
      check("model_stall_cnt", int'(stall_cnt), m_cnt);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic mid();
    @(negedge CLK); #1;
  endtask

  task automatic clr_in();
    ihit = 0; dhit = 0; mem_dren = 0; mem_dwen = 0; branch_taken = 0; jump_id = 0;
    ex_memread = 0; halt_wb = 0; ex_rt = 0; id_rs = 0; id_rt = 0;
  endtask

  task automatic do_reset();
    nRST = 0; clr_in(); tick(); nRST = 1;
  endtask

  initial begin
    nRST = 0; clr_in();
    tick();
    chk_en = 1'b1;

    // Reset state
    mid();
    check("rst_outs", int'(outs), int'(O_NONE));
    check("rst_halt", int'(halt), 0);
    check("rst_cnt", int'(stall_cnt), 0);
    tick(); nRST = 1;

    // 1: free-running fetches
    ihit = 1;
    for (int i = 0; i < 5; i++) begin
      mid(); check("t1_outs", int'(outs), int'(O_ADV)); tick();
    end
    check("t1_cnt", int'(stall_cnt), 0);

    // 2: ihit first, dhit after 3 cycles
    mem_dren = 1; ihit = 1; dhit = 0;
    for (int i = 0; i < 3; i++) begin
      mid(); check("t2_wait_outs", int'(outs), int'(O_NONE)); tick();
    end
    ihit = 0; dhit = 1;
    mid(); check("t2_adv_outs", int'(outs), int'(O_ADV)); check("t2_cnt", int'(stall_cnt), 3);
    tick();

    // 3: dhit first, repeated, then ihit
    do_reset();
    mem_dren = 1; dhit = 1; ihit = 0;
    mid(); check("t3_c0_outs", int'(outs), int'(O_NONE)); tick();
    mid(); check("t3_c1_outs", int'(outs), int'(O_NONE)); tick();
    dhit = 0; ihit = 1;
    mid(); check("t3_c2_outs", int'(outs), int'(O_ADV)); check("t3_cnt", int'(stall_cnt), 2);
    tick();
    clr_in();

    // 4: override priorities
    ihit = 1; ex_memread = 1; ex_rt = 5; id_rs = 5;
    mid(); check("t4_bubble", int'(outs), int'(O_BUBBLE)); tick();
    ex_rt = 0; id_rs = 0;
    mid(); check("t4_rt0", int'(outs), int'(O_ADV)); tick();
    ex_rt = 5; id_rt = 5; branch_taken = 1;
    mid(); check("t4_branch", int'(outs), int'(O_BRANCH)); tick();
    branch_taken = 0; ex_memread = 0; jump_id = 1;
    mid(); check("t4_jump", int'(outs), int'(O_JUMP)); tick();
    ex_memread = 1;
    mid(); check("t4_jump_lu", int'(outs), int'(O_BUBBLE)); tick();
    clr_in();

    // 5: halt
    do_reset();
    ihit = 1; halt_wb = 1;
    mid(); check("t5_adv", int'(outs), int'(O_ADV)); check("t5_halt_pre", int'(halt), 0); tick();
    halt_wb = 0; dhit = 1;
    for (int i = 0; i < 3; i++) begin
      mid(); check("t5_frozen_outs", int'(outs), int'(O_NONE)); check("t5_halt", int'(halt), 1); tick();
    end
    check("t5_cnt_frozen", int'(stall_cnt), 0);
    nRST = 0; tick(); nRST = 1; dhit = 0;
    mid(); check("t5_rst_halt", int'(halt), 0); check("t5_rst_cnt", int'(stall_cnt), 0);
    check("t5_rst_outs", int'(outs), int'(O_ADV)); tick();

    // 6: saturation
    do_reset();
    for (int i = 0; i < 18; i++) tick();
    mid(); check("t6_sat", int'(stall_cnt), CMAX); tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      nRST         = ($urandom_range(0, 149) != 0);
      ihit         = ($urandom_range(0, 2) != 0);
      dhit         = ($urandom_range(0, 2) == 0);
      mem_dren     = ($urandom_range(0, 3) == 0);
      mem_dwen     = ($urandom_range(0, 4) == 0);
      branch_taken = ($urandom_range(0, 6) == 0);
      jump_id      = ($urandom_range(0, 5) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      halt_wb      = ($urandom_range(0, 59) == 0);
      ex_rt        = REG_W'($urandom_range(0, 3));
      id_rs        = REG_W'($urandom_range(0, 3));
      id_rt        = REG_W'($urandom_range(0, 3));
      tick();
    end

    mid();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
